// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the fetch-stage state encoding.
package cpu_pkg;

    localparam int ADDR_W      = 64;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: captures a fetched word and its PC.
// A flush turns the slot into a bubble and wins over a simultaneous load.
module ifid_register
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  capture_pc,
    input  logic [INSTR_W-1:0] capture_instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               valid
);

    logic [ADDR_W-1:0]  pc_reg;
    logic [INSTR_W-1:0] instruction_reg;
    logic               valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= '0;
            instruction_reg <= '0;
            valid_reg       <= 1'b0;
        end else if (flush) begin
            // Payload fields are left as-is; only the valid bit matters downstream.
            valid_reg <= 1'b0;
        end else if (load) begin
            pc_reg          <= capture_pc;
            instruction_reg <= capture_instruction;
            valid_reg       <= 1'b1;
        end
    end

    assign pc          = pc_reg;
    assign instruction = instruction_reg;
    assign valid       = valid_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, RUN/HALT control and IF/ID capture.
// Build option IFETCH_ALIGN_CHECK_EN: misaligned branch targets raise a sticky fault and halt.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          MEM_SIZE = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [INSTR_W-1:0] ifid_instruction,
    output logic               ifid_valid,
    output logic               halted,
    output logic               fault
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_SIZE);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              load, flush;
    logic              past_end;

    // Compare one bit wider so a PC near the top of the address space cannot wrap past the limit.
    assign past_end = ({1'b0, pc_reg} + (ADDR_W + 1)'(INSTR_BYTES)) > MEM_LIMIT;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_reg, fault_next;
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        load       = 1'b0;
        flush      = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        fault_next = fault_reg;
`endif
        if (branch_taken) begin
            flush = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
            if (|branch_target[1:0]) begin
                fault_next = 1'b1;
                state_next = HALT;
            end else begin
                pc_next    = branch_target;
                state_next = RUN;
            end
`else
            pc_next    = branch_target & ~64'd3;
            state_next = RUN;
`endif
        end else if (state_reg == RUN) begin
            // Halt wins over stall so a stalled pipeline still notices the end of memory.
            if (past_end) begin
                state_next = HALT;
                flush      = 1'b1;
            end else if (!stall) begin
                load    = 1'b1;
                pc_next = pc_reg + ADDR_W'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fault_next;
        end
    end
    assign fault = fault_reg;
`else
    assign fault = 1'b0;
`endif

    ifid_register u_ifid (
        .clk                 (clk),
        .rst                 (rst),
        .load                (load),
        .flush               (flush),
        .capture_pc          (pc_reg),
        .capture_instruction (imem_data),
        .pc                  (ifid_pc),
        .instruction         (ifid_instruction),
        .valid               (ifid_valid)
    );

    assign imem_address = pc_reg;
    assign halted       = (state_reg == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit with a 16-byte program: directed vector table,
// misaligned-branch sequence and a randomized run against a behavioural model.
module tb_instruction_fetch_unit;

    localparam int MEM_BYTES = 16;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken;
    logic [63:0] branch_target;
    logic [63:0] imem_address;
    logic [31:0] imem_data;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instruction;
    logic        ifid_valid, halted, fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [4];

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(64'h0), .MEM_SIZE(MEM_BYTES)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_address     (imem_address),
        .imem_data        (imem_data),
        .ifid_pc          (ifid_pc),
        .ifid_instruction (ifid_instruction),
        .ifid_valid       (ifid_valid),
        .halted           (halted),
        .fault            (fault)
    );

    function automatic logic [31:0] mem_read(input logic [63:0] a);
        if (a < 64'(MEM_BYTES)) return mem[a[3:2]];
        return 32'hFFFF_FFFF;
    endfunction

    assign imem_data = mem_read(imem_address);

    // Behavioural model of the fetch stage, advanced once per rising edge.
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    bit          m_valid, m_halted, m_fault;

    function automatic bit align_check_on();
`ifdef IFETCH_ALIGN_CHECK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input bit r, input bit s, input bit b, input logic [63:0] t);
        if (r) begin
            m_pc = 64'h0; m_ipc = 64'h0; m_instr = 32'h0;
            m_valid = 0; m_halted = 0; m_fault = 0;
        end else if (b) begin
            m_valid = 0;
            if (align_check_on() && (t % 4 != 0)) begin
                m_fault  = 1;
                m_halted = 1;
            end else begin
                m_pc     = t - (t % 4);
                m_halted = 0;
            end
        end else if (!m_halted) begin
            if (m_pc + 4 > MEM_BYTES) begin
                m_halted = 1;
                m_valid  = 0;
            end else if (!s) begin
                m_ipc   = m_pc;
                m_instr = mem_read(m_pc);
                m_valid = 1;
                m_pc    = m_pc + 4;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input bit r, input bit s, input bit b, input logic [63:0] t);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        @(posedge clk);
        model_step(r, s, b, t);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " addr"},   imem_address,             m_pc);
        chk({tag, " ipc"},    ifid_pc,                  m_ipc);
        chk({tag, " instr"},  64'(ifid_instruction),    64'(m_instr));
        chk({tag, " valid"},  64'(ifid_valid),          64'(m_valid));
        chk({tag, " halted"}, 64'(halted),              64'(m_halted));
        chk({tag, " fault"},  64'(fault),               64'(m_fault));
    endtask

    typedef struct {
        bit          r, s, b;
        logic [63:0] t;
        logic [63:0] addr, ipc;
        logic [31:0] instr;
        bit          valid, hlt;
    } vec_t;

    vec_t vecs [16];

    initial begin
        mem[0] = 32'h8b1f03e5; mem[1] = 32'hf84000a4;
        mem[2] = 32'h8b040086; mem[3] = 32'hf80010a6;
        rst = 1; stall = 0; branch_taken = 0; branch_target = 0;
        m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_halted = 0; m_fault = 0;

        //            r  s  b  tgt    addr   ipc    instr          v  h
        vecs[0]  = '{1, 0, 0, 64'h0, 64'h0, 64'h0, 32'h0,         0, 0};
        vecs[1]  = '{0, 0, 0, 64'h0, 64'h4, 64'h0, 32'h8b1f03e5, 1, 0};
        vecs[2]  = '{0, 0, 0, 64'h0, 64'h8, 64'h4, 32'hf84000a4, 1, 0};
        vecs[3]  = '{0, 1, 0, 64'h0, 64'h8, 64'h4, 32'hf84000a4, 1, 0};
        vecs[4]  = '{0, 1, 0, 64'h0, 64'h8, 64'h4, 32'hf84000a4, 1, 0};
        vecs[5]  = '{0, 1, 0, 64'h0, 64'h8, 64'h4, 32'hf84000a4, 1, 0};
        vecs[6]  = '{0, 0, 0, 64'h0, 64'hc, 64'h8, 32'h8b040086, 1, 0};
        vecs[7]  = '{0, 1, 1, 64'h4, 64'h4, 64'h8, 32'h8b040086, 0, 0};
        vecs[8]  = '{0, 0, 0, 64'h0, 64'h8, 64'h4, 32'hf84000a4, 1, 0};
        vecs[9]  = '{0, 0, 0, 64'h0, 64'hc, 64'h8, 32'h8b040086, 1, 0};
        vecs[10] = '{0, 0, 0, 64'h0, 64'h10, 64'hc, 32'hf80010a6, 1, 0};
        vecs[11] = '{0, 0, 0, 64'h0, 64'h10, 64'hc, 32'hf80010a6, 0, 1};
        vecs[12] = '{0, 1, 0, 64'h0, 64'h10, 64'hc, 32'hf80010a6, 0, 1};
        vecs[13] = '{0, 0, 1, 64'h0, 64'h0, 64'hc, 32'hf80010a6, 0, 0};
        vecs[14] = '{0, 0, 0, 64'h0, 64'h4, 64'h0, 32'h8b1f03e5, 1, 0};
        vecs[15] = '{1, 0, 1, 64'h8, 64'h0, 64'h0, 32'h0,         0, 0};

        for (int i = 0; i < 16; i++) begin
            tick(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].t);
            chk($sformatf("vec%0d addr", i),   imem_address,          vecs[i].addr);
            chk($sformatf("vec%0d ipc", i),    ifid_pc,               vecs[i].ipc);
            chk($sformatf("vec%0d instr", i),  64'(ifid_instruction), 64'(vecs[i].instr));
            chk($sformatf("vec%0d valid", i),  64'(ifid_valid),       64'(vecs[i].valid));
            chk($sformatf("vec%0d halted", i), 64'(halted),           64'(vecs[i].hlt));
            chk($sformatf("vec%0d fault", i),  64'(fault),            64'h0);
            $display("vec %0d: addr=%0h ipc=%0h instr=%h valid=%0b halted=%0b",
                     i, imem_address, ifid_pc, ifid_instruction, ifid_valid, halted);
        end

        // Misaligned branch target 0x6 taken from pc=8.
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 64'h6);
        $display("misaligned: addr=%0h fault=%0b halted=%0b", imem_address, fault, halted);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("mis addr", imem_address, 64'h8);
        chk("mis fault", 64'(fault), 64'h1);
        chk("mis halted", 64'(halted), 64'h1);
        chk("mis valid", 64'(ifid_valid), 64'h0);
        tick(0, 0, 1, 64'h0);
        chk("mis resume halted", 64'(halted), 64'h0);
        chk("mis resume fault", 64'(fault), 64'h1);
        chk("mis resume addr", imem_address, 64'h0);
        tick(1, 0, 0, 0);
        chk("mis rst fault", 64'(fault), 64'h0);
`else
        chk("mis addr", imem_address, 64'h4);
        chk("mis fault", 64'(fault), 64'h0);
        chk("mis halted", 64'(halted), 64'h0);
        chk("mis valid", 64'(ifid_valid), 64'h0);
        tick(0, 0, 0, 0);
        chk("mis next ipc", ifid_pc, 64'h4);
        chk("mis next instr", 64'(ifid_instruction), 64'hf84000a4);
        chk("mis next valid", 64'(ifid_valid), 64'h1);
`endif

        // Randomized run against the model.
        tick(1, 0, 0, 0);
        check_model("rand reset");
        for (int i = 0; i < 400; i++) begin
            bit          r, s, b;
            logic [63:0] t;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 15);
            t = 64'($urandom_range(0, 24));
            tick(r, s, b, t);
            check_model($sformatf("rand%0d", i));
            $display("rand %0d: rst=%0b stall=%0b br=%0b tgt=%0h -> addr=%0h valid=%0b halted=%0b fault=%0b",
                     i, r, s, b, t, imem_address, ifid_valid, halted, fault);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
